// File: rtl/nvme_doorbell_tlp_gen.sv
// Doorbell request FIFO feeding a 1-DW Memory Write TLP generator on the
// 128-bit AXI4-Stream RQ interface, targeting the controller doorbells in BAR0.
module nvme_doorbell_tlp_gen #(
  parameter int unsigned C_DATA_WIDTH        = 128,
  parameter int unsigned AXI4_RQ_TUSER_WIDTH = 62,
  parameter int unsigned KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int unsigned QID_WIDTH           = 4,
  parameter int unsigned FIFO_DEPTH          = 8
) (
  input  logic                           user_clk,
  input  logic                           user_reset,
  input  logic                           user_lnk_up,
  input  logic                           cfg_done,
  input  logic [63:0]                    bar0_addr,
  input  logic [3:0]                     cap_dstrd,
  input  logic [15:0]                    requester_id,
  input  logic                           db_req_valid,
  output logic                           db_req_ready,
  input  logic [QID_WIDTH-1:0]           db_req_qid,
  input  logic                           db_req_is_cq,
  input  logic [15:0]                    db_req_value,
  output logic [C_DATA_WIDTH-1:0]        db_s_axis_rq_tdata,
  output logic [AXI4_RQ_TUSER_WIDTH-1:0] db_s_axis_rq_tuser,
  output logic [KEEP_WIDTH-1:0]          db_s_axis_rq_tkeep,
  output logic                           db_s_axis_rq_tlast,
  output logic                           db_s_axis_rq_tvalid,
  input  logic [3:0]                     db_s_axis_rq_tready,
  output logic                           db_busy,
  output logic [31:0]                    db_issued_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = QID_WIDTH + 1 + 16;

  typedef enum logic [1:0] {S_IDLE, S_DESC, S_DATA} state_e;

  state_e                         state_q, state_d;
  logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic                           ready_q, ready_d;
  logic                           busy_q, busy_d;
  logic [15:0]                    value_q, value_d;
  logic [31:0]                    issued_q, issued_d;
  logic [C_DATA_WIDTH-1:0]        tdata_q, tdata_d;
  logic [AXI4_RQ_TUSER_WIDTH-1:0] tuser_q, tuser_d;
  logic [KEEP_WIDTH-1:0]          tkeep_q, tkeep_d;
  logic                           tlast_q, tlast_d;
  logic                           tvalid_q, tvalid_d;
  logic [ENT_W-1:0]               mem_q [FIFO_DEPTH];

  logic                           push, pop;
  logic [ENT_W-1:0]               rd_ent;
  logic [63:0]                    addr_c;
  logic                           unused_tready;

  assign unused_tready = ^db_s_axis_rq_tready[3:1];
  assign rd_ent        = mem_q[rd_ptr_q];

  // Doorbell for index 2*qid+is_cq, spaced by 4 << DSTRD bytes above BAR0+0x1000.
  assign addr_c = bar0_addr + 64'h1000
                + (64'(rd_ent[ENT_W-1:16]) << (5'd2 + 5'(cap_dstrd)));

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    value_d  = value_q;
    issued_d = issued_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    push     = db_req_valid & ready_q;
    pop      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && cfg_done && user_lnk_up) begin
          pop      = 1'b1;
          state_d  = S_DESC;
          value_d  = rd_ent[15:0];
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          tkeep_d  = KEEP_WIDTH'(4'hF);
          tuser_d  = AXI4_RQ_TUSER_WIDTH'(8'h0F);
          tdata_d  = C_DATA_WIDTH'({7'd0, 1'b0, 16'd0, 8'h00, requester_id,
                                    1'b0, 4'b0001, 11'd1, addr_c & ~64'h3});
        end
      end
      S_DESC: begin
        if (db_s_axis_rq_tready[0]) begin
          state_d = S_DATA;
          tkeep_d = KEEP_WIDTH'(4'h1);
          tlast_d = 1'b1;
          tdata_d = C_DATA_WIDTH'({16'h0, value_q});
        end
      end
      S_DATA: begin
        if (db_s_axis_rq_tready[0]) begin
          state_d  = S_IDLE;
          issued_d = issued_q + 32'd1;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          tkeep_d  = '0;
          tuser_d  = '0;
          tdata_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    ready_d = (count_d != CNT_W'(FIFO_DEPTH));
    busy_d  = (count_d != '0) || (state_d != S_IDLE);
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      value_q  <= '0;
      issued_q <= '0;
      tdata_q  <= '0;
      tuser_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      value_q  <= value_d;
      issued_q <= issued_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge user_clk) begin
    if (push) mem_q[wr_ptr_q] <= {db_req_qid, db_req_is_cq, db_req_value};
  end

  assign db_req_ready        = ready_q;
  assign db_busy             = busy_q;
  assign db_issued_cnt       = issued_q;
  assign db_s_axis_rq_tdata  = tdata_q;
  assign db_s_axis_rq_tuser  = tuser_q;
  assign db_s_axis_rq_tkeep  = tkeep_q;
  assign db_s_axis_rq_tlast  = tlast_q;
  assign db_s_axis_rq_tvalid = tvalid_q;

endmodule

// File: tb/tb_nvme_doorbell_tlp_gen.sv
// Scoreboard bench for nvme_doorbell_tlp_gen: directed doorbell requests queue
// expected beats; a negedge monitor pops and compares on every handshake.
module tb_nvme_doorbell_tlp_gen;

  logic          user_clk = 1'b0;
  logic          user_reset, user_lnk_up, cfg_done;
  logic [63:0]   bar0_addr;
  logic [3:0]    cap_dstrd;
  logic [15:0]   requester_id;
  logic          db_req_valid, db_req_ready, db_req_is_cq;
  logic [3:0]    db_req_qid;
  logic [15:0]   db_req_value;
  logic [127:0]  tdata;
  logic [61:0]   tuser;
  logic [3:0]    tkeep;
  logic          tlast, tvalid;
  logic [3:0]    tready;
  logic          db_busy;
  logic [31:0]   db_issued_cnt;

  always #5 user_clk = ~user_clk;

  nvme_doorbell_tlp_gen dut (
    .user_clk(user_clk), .user_reset(user_reset), .user_lnk_up(user_lnk_up),
    .cfg_done(cfg_done), .bar0_addr(bar0_addr), .cap_dstrd(cap_dstrd),
    .requester_id(requester_id), .db_req_valid(db_req_valid),
    .db_req_ready(db_req_ready), .db_req_qid(db_req_qid),
    .db_req_is_cq(db_req_is_cq), .db_req_value(db_req_value),
    .db_s_axis_rq_tdata(tdata), .db_s_axis_rq_tuser(tuser),
    .db_s_axis_rq_tkeep(tkeep), .db_s_axis_rq_tlast(tlast),
    .db_s_axis_rq_tvalid(tvalid), .db_s_axis_rq_tready(tready),
    .db_busy(db_busy), .db_issued_cnt(db_issued_cnt)
  );

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   keep;
    logic         last;
    logic [61:0]  user;
  } beat_t;

  beat_t exp_q[$];
  beat_t cur_b, prev_b;
  logic  prev_valid = 1'b0, prev_stall = 1'b0;
  int    n_vec = 0, n_err = 0, n_beats = 0;

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected descriptor and data beats for one doorbell write (addr hand-computed).
  task automatic expect_tlp(input logic [63:0] addr, input logic [15:0] val);
    beat_t b;
    b.data = {32'h0, requester_id, 16'h0801, addr};
    b.keep = 4'hF;
    b.last = 1'b0;
    b.user = 62'h0F;
    exp_q.push_back(b);
    b.data = {112'h0, val};
    b.keep = 4'h1;
    b.last = 1'b1;
    exp_q.push_back(b);
  endtask

  always @(negedge user_clk) begin
    cur_b = {tdata, tkeep, tlast, tuser};
    if (prev_stall)
      check("hold_stable", {cur_b, tvalid}, {prev_b, prev_valid});
    if (!user_reset && tvalid && tready[0]) begin
      n_beats++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_beat: got data %0h last %0b, expected no beat", tdata, tlast);
      end else begin
        check("beat", 200'(cur_b), 200'(exp_q.pop_front()));
      end
    end
    prev_b     = cur_b;
    prev_valid = tvalid;
    prev_stall = tvalid && !tready[0] && !user_reset;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge user_clk);
      #1;
    end
  endtask

  task automatic send_req(input logic [3:0] q, input logic cq, input logic [15:0] v);
    int n = 0;
    db_req_qid   = q;
    db_req_is_cq = cq;
    db_req_value = v;
    db_req_valid = 1'b1;
    while (!db_req_ready && n < 100) begin
      cyc(1);
      n++;
    end
    if (!db_req_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL req_ready_timeout: got ready 0, expected 1");
    end
    cyc(1);
    db_req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cyc(1);
      if (!db_busy && exp_q.size() == 0) ok = 1'b1;
    end
    check(name, 200'(ok), 200'(1'b1));
  endtask

  task automatic wait_valid(input string name, input logic need_last, input int budget);
    logic ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cyc(1);
      if (tvalid && (tlast || !need_last)) ok = 1'b1;
    end
    check(name, 200'(ok), 200'(1'b1));
  endtask

  initial begin
    int beats0;
    user_reset   = 1'b1;
    user_lnk_up  = 1'b1;
    cfg_done     = 1'b1;
    bar0_addr    = 64'hF000_0000;
    cap_dstrd    = 4'd0;
    requester_id = 16'h0100;
    db_req_valid = 1'b0;
    db_req_qid   = '0;
    db_req_is_cq = 1'b0;
    db_req_value = '0;
    tready       = 4'hF;
    cyc(3);
    user_reset = 1'b0;
    cyc(1);
    check("rst_tvalid", 200'(tvalid), 200'(1'b0));
    check("rst_tdata", 200'({tdata, tkeep, tlast, tuser}), 200'(0));
    check("rst_cnt", 200'(db_issued_cnt), 200'(0));
    check("rst_busy", 200'(db_busy), 200'(1'b0));
    check("rst_ready", 200'(db_req_ready), 200'(1'b1));

    // Single SQ doorbell: qid 1 -> offset 0x1008
    expect_tlp(64'hF000_1008, 16'h0005);
    send_req(4'd1, 1'b0, 16'h0005);
    wait_idle("sq_done", 50);
    check("sq_cnt", 200'(db_issued_cnt), 200'(1));

    // CQ doorbell with stride 2: qid 3 CQ -> 0x1000 + (7 << 4) = 0x1070
    cap_dstrd = 4'd2;
    expect_tlp(64'hF000_1070, 16'h1234);
    send_req(4'd3, 1'b1, 16'h1234);
    wait_idle("cq_done", 50);
    bar0_addr = 64'h0000_0012_3456_7000;
    expect_tlp(64'h0000_0012_3456_8070, 16'hBEEF);
    send_req(4'd3, 1'b1, 16'hBEEF);
    wait_idle("cq64_done", 50);
    check("cq_cnt", 200'(db_issued_cnt), 200'(3));

    // Backpressure: 5 stalled cycles in DESC, 3 in DATA
    bar0_addr = 64'hF000_0000;
    cap_dstrd = 4'd0;
    tready    = 4'h0;
    beats0    = n_beats;
    expect_tlp(64'hF000_1010, 16'hABCD);
    send_req(4'd2, 1'b0, 16'hABCD);
    wait_valid("bp_desc", 1'b0, 20);
    cyc(5);
    tready = 4'h1;
    cyc(1);
    tready = 4'h0;
    check("bp_in_data", 200'({tvalid, tlast}), 200'(2'b11));
    cyc(3);
    tready = 4'hF;
    wait_idle("bp_done", 50);
    check("bp_beats", 200'(n_beats - beats0), 200'(2));
    check("bp_cnt", 200'(db_issued_cnt), 200'(4));

    // FIFO full: 8 accepted while gated, 9th refused
    cfg_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_tlp(64'hF000_1000 + 64'(8 * i), 16'h0100 + 16'(i));
      send_req(4'(i), 1'b0, 16'h0100 + 16'(i));
    end
    check("full_ready", 200'(db_req_ready), 200'(1'b0));
    db_req_qid   = 4'd0;
    db_req_value = 16'hDEAD;
    db_req_valid = 1'b1;
    cyc(3);
    db_req_valid = 1'b0;
    check("full_gated", 200'({db_req_ready, db_busy, tvalid}), 200'(3'b010));
    cfg_done = 1'b1;
    wait_idle("full_drain", 300);
    check("full_cnt", 200'(db_issued_cnt), 200'(12));

    // Gating: cfg_done drops during DATA; next TLP waits
    cfg_done = 1'b0;
    expect_tlp(64'hF000_1020, 16'h0044);
    send_req(4'd4, 1'b0, 16'h0044);
    expect_tlp(64'hF000_102C, 16'h0055);
    send_req(4'd5, 1'b1, 16'h0055);
    cfg_done = 1'b1;
    wait_valid("gate_data", 1'b1, 20);
    cfg_done = 1'b0;
    cyc(10);
    check("gate_hold", 200'({tvalid, db_busy}), 200'(2'b01));
    check("gate_cnt", 200'(db_issued_cnt), 200'(13));
    check("gate_pending", 200'(exp_q.size()), 200'(2));
    cfg_done = 1'b1;
    wait_idle("gate_done", 50);
    check("gate_cnt2", 200'(db_issued_cnt), 200'(14));

    // Reset while in DESC with one more entry queued: both dropped
    tready = 4'h0;
    send_req(4'd6, 1'b0, 16'h0066);
    send_req(4'd7, 1'b0, 16'h0077);
    wait_valid("rst_desc", 1'b0, 20);
    cyc(2);
    user_reset = 1'b1;
    cyc(1);
    user_reset = 1'b0;
    check("rstm_out", 200'({tdata, tkeep, tlast, tuser, tvalid}), 200'(0));
    check("rstm_state", 200'({db_issued_cnt, db_req_ready, db_busy}), 200'({32'd0, 1'b1, 1'b0}));
    tready = 4'hF;
    cyc(10);
    check("rstm_quiet", 200'({db_busy, db_issued_cnt}), 200'(0));
    expect_tlp(64'hF000_1000, 16'h0007);
    send_req(4'd0, 1'b0, 16'h0007);
    wait_idle("rstm_after", 50);
    check("rstm_cnt", 200'(db_issued_cnt), 200'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nvme_doorbell_tlp_gen.md
Name: nvme_doorbell_tlp_gen

Overview:
- Upstream feeder of the doorbell RQ input (db_s_axis_rq_*) of the PCIe requester arbiter.
- Accepts doorbell update requests (queue ID, SQ tail / CQ head value) from the NVMe queue managers and buffers them in a small FIFO.
- Converts each request into a 1-DW Memory Write TLP in the 128-bit AXI4-Stream RQ descriptor format, aimed at the controller's doorbell register in BAR0.

Parameters:
- C_DATA_WIDTH, 128, RQ data width; only 128 is supported.
- AXI4_RQ_TUSER_WIDTH, 62, RQ tuser width.
- KEEP_WIDTH, C_DATA_WIDTH/32, tkeep width.
- QID_WIDTH, 4, queue ID width.
- FIFO_DEPTH, 8, request FIFO entries; must be a power of 2, at least 2.

Ports:
- user_clk  in  1  clock; all logic on rising edge.
- user_reset  in  1  synchronous, active-high reset.
- user_lnk_up  in  1  PCIe link up.
- cfg_done  in  1  controller init complete; TLP issue is enabled only when high.
- bar0_addr  in  64  controller BAR0 base; bits [11:0] are zero.
- cap_dstrd  in  4  CAP.DSTRD doorbell stride exponent.
- requester_id  in  16  own BDF.
- db_req_valid  in  1  doorbell request valid.
- db_req_ready  out  1  FIFO not full.
- db_req_qid  in  QID_WIDTH  queue ID.
- db_req_is_cq  in  1  0 = SQ tail doorbell, 1 = CQ head doorbell.
- db_req_value  in  16  new tail/head value.
- db_s_axis_rq_tdata  out  C_DATA_WIDTH  TLP data.
- db_s_axis_rq_tuser  out  AXI4_RQ_TUSER_WIDTH  RQ sideband.
- db_s_axis_rq_tkeep  out  KEEP_WIDTH  dword enables.
- db_s_axis_rq_tlast  out  1  last beat.
- db_s_axis_rq_tvalid  out  1  beat valid.
- db_s_axis_rq_tready  in  4  core ready; only bit 0 is used.
- db_busy  out  1  FIFO non-empty or TLP in flight.
- db_issued_cnt  out  32  count of completed doorbell TLPs; wraps.

Behaviour:
- Reset: FIFO empty, FSM in IDLE, tvalid/tlast = 0, tdata/tuser/tkeep = 0, db_issued_cnt = 0, db_busy = 0. db_req_ready is 1 from the first cycle after reset release.
- FIFO:
  - Push on db_req_valid & db_req_ready. Pop when the FSM loads an entry.
  - db_req_ready = !full. Push and pop may occur in the same cycle, including when full: the push is refused that cycle because ready is based on registered full.
  - Pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.
- Address: bar0_addr + 0x1000 + ((2*qid + is_cq) << (2 + cap_dstrd)), 64-bit unsigned. Computed when the entry is popped and registered.
- FSM:
  - IDLE -> DESC when FIFO non-empty & cfg_done & user_lnk_up. Pop the entry and register the address and value.
  - DESC: tvalid = 1, tkeep = 4'hF, tlast = 0.
    - tdata[63:0] = {addr[63:2], 2'b00}.
    - tdata[74:64] = 11'd1 (dword count).
    - tdata[78:75] = 4'b0001 (MemWr).
    - tdata[79] = 0.
    - tdata[95:80] = requester_id.
    - tdata[103:96] = 8'h00 (tag).
    - tdata[119:104] = 0.
    - tdata[120] = 0.
    - tdata[127:121] = 0.
    - tuser[3:0] = 4'hF (first_be), tuser[7:4] = 4'h0 (last_be), all other tuser bits 0.
    - Advance to DATA on tready[0].
  - DATA: tvalid = 1, tkeep = 4'h1, tlast = 1, tdata[31:0] = {16'h0, value}, rest of tdata 0, tuser same as DESC.
    - On tready[0]: db_issued_cnt increments; go to IDLE.
- Throughput: minimum 3 cycles per TLP (IDLE, DESC, DATA); back-to-back requests issue with one idle cycle between TLPs.
- All stream outputs are registered. While tvalid = 1 and tready[0] = 0, every output is held stable.
- cfg_done or user_lnk_up dropping mid-TLP does not abort it: the current TLP completes, and no new TLP starts until both are high. The FIFO keeps accepting requests meanwhile.
- Reset mid-TLP: on the cycle after user_reset, all outputs return to their reset values, the partial TLP is dropped, and FIFO contents are discarded.
- db_busy = (count != 0) | (state != IDLE).

Test Plan:
- Single SQ doorbell: bar0 = 0xF000_0000, dstrd = 0, qid = 1, is_cq = 0, value = 0x0005, cfg_done = 1, tready = 4'hF.
  - Beat 1: addr field 0xF000_1008, tdata[78:64] = {4'b0001, 11'd1}, tkeep = F.
  - Beat 2: tdata[31:0] = 0x0000_0005, tkeep = 1, tlast = 1.
  - db_issued_cnt = 1.
- CQ doorbell with stride: dstrd = 2, qid = 3, is_cq = 1 -> offset 0x1000 + (7 << 4) = 0x1070.
- Backpressure: hold tready = 0 for 5 cycles in DESC, then 3 cycles in DATA -> outputs stable throughout; exactly 2 beats transferred; count +1.
- FIFO full: cfg_done = 0, push 9 requests with FIFO_DEPTH = 8 -> db_req_ready = 0 after the 8th push. Raise cfg_done -> 8 TLPs emitted in push order, values intact; db_busy falls after the last tlast.
- Gating: drop cfg_done during DATA -> that TLP completes; the next queued TLP waits until cfg_done = 1.
- Reset in DESC: assert user_reset for 1 cycle -> tvalid = 0 next cycle, FIFO empty, db_issued_cnt = 0, db_req_ready = 1.
